serial_subtractor: RTL and testbench

- Bit-serial WIDTH-bit subtractor computing a - b - bin, LSB first, one bit per clock.
- Drives the existing 1-bit full_subtractor stage with operand bits and a registered borrow chain.
- Collects its diff/borrow outputs into a word result.
- Sits directly upstream of and around full_subtractor; a low-area alternative to a ripple subtractor.

---
 rtl/serial_sub_pkg.sv | 17 +
 rtl/full_subtractor.sv | 13 +
 rtl/serial_subtractor.sv | 129 ++++++++++++
 tb/tb_serial_subtractor.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_sub_pkg.sv
// Shared types and helpers for the bit-serial subtractor.
package serial_sub_pkg;

  localparam int unsigned DefaultWidth = 8;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

  // Counter must be able to hold the value WIDTH after the final increment.
  function automatic int unsigned cnt_width(input int unsigned width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor: diff = a - b - c, brw = borrow out.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic diff,
  output logic brw
);

  assign diff = a ^ b ^ c;
  assign brw  = (~a & b) | (~a & c) | (b & c);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor, a - b - bin, LSB first, one bit per clock.
// Optional signed-overflow output enabled by defining SERIAL_SUB_OVF_EN.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned CntW = cnt_width(WIDTH);
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  state_e           r_state;
  state_e           w_state_next;
  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic [WIDTH-1:0] r_res;
  logic [WIDTH-1:0] w_res_next;
  logic [WIDTH-1:0] r_diff;
  logic             r_bout;
  logic             r_br;
  logic [CntW-1:0]  r_cnt;
  logic             w_d;
  logic             w_br_next;
  logic             w_load;
  logic             w_last;
`ifdef SERIAL_SUB_OVF_EN
  logic             r_ovf;
`endif

  full_subtractor u_fs (
    .a    (r_a_sh[0]),
    .b    (r_b_sh[0]),
    .c    (r_br),
    .diff (w_d),
    .brw  (w_br_next)
  );

  // Start is honoured in IDLE and, for back-to-back operation, in DONE.
  assign w_load = start && (r_state != StRun);
  assign w_last = (r_state == StRun) && (r_cnt == LastCnt);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:  if (start) w_state_next = StRun;
      StRun:   if (r_cnt == LastCnt) w_state_next = StDone;
      StDone:  w_state_next = start ? StRun : StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  // New result bit enters at the MSB; after WIDTH shifts bit 0 sits at the LSB.
  always_comb begin
    w_res_next            = r_res >> 1;
    w_res_next[WIDTH-1]   = w_d;
  end

  // Operand capture, serial shifting and result publication.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a_sh <= '0;
      r_b_sh <= '0;
      r_res  <= '0;
      r_br   <= 1'b0;
      r_cnt  <= '0;
      r_diff <= '0;
      r_bout <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      r_ovf  <= 1'b0;
`endif
    end else if (w_load) begin
      r_a_sh <= a;
      r_b_sh <= b;
      r_br   <= bin;
      r_cnt  <= '0;
    end else if (r_state == StRun) begin
      r_a_sh <= r_a_sh >> 1;
      r_b_sh <= r_b_sh >> 1;
      r_br   <= w_br_next;
      r_cnt  <= r_cnt + CntW'(1);
      r_res  <= w_res_next;
      if (w_last) begin
        r_diff <= w_res_next;
        r_bout <= w_br_next;
`ifdef SERIAL_SUB_OVF_EN
        // Signed overflow iff the MSB stage's borrow-in and borrow-out differ.
        r_ovf  <= r_br ^ w_br_next;
`endif
      end
    end
  end

  // Status and result outputs.
  always_comb begin
    busy = (r_state == StRun);
    done = (r_state == StDone);
    diff = r_diff;
    bout = r_bout;
`ifdef SERIAL_SUB_OVF_EN
    ovf  = r_ovf;
`endif
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor at WIDTH=8 and WIDTH=1.
module tb_serial_subtractor;

  typedef struct {
    logic [31:0] diff;
    logic        bout;
    logic        ovf;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic       start8, bin8, busy8, done8, bout8, ovf8;
  logic [7:0] a8, b8, diff8;
  logic       start1, bin1, busy1, done1, bout1, ovf1;
  logic [0:0] a1, b1, diff1;

  int   checks = 0;
  int   errors = 0;
  exp_t q8[$];
  exp_t q1[$];
  exp_t e8, e1;
  logic [7:0] hold8 = 8'h00;

  serial_subtractor #(.WIDTH(8)) u_dut8 (
    .clk   (clk),
    .rst   (rst),
    .start (start8),
    .a     (a8),
    .b     (b8),
    .bin   (bin8),
    .busy  (busy8),
    .done  (done8),
    .diff  (diff8),
    .bout  (bout8)
`ifdef SERIAL_SUB_OVF_EN
    ,
    .ovf   (ovf8)
`endif
  );

  serial_subtractor #(.WIDTH(1)) u_dut1 (
    .clk   (clk),
    .rst   (rst),
    .start (start1),
    .a     (a1),
    .b     (b1),
    .bin   (bin1),
    .busy  (busy1),
    .done  (done1),
    .diff  (diff1),
    .bout  (bout1)
`ifdef SERIAL_SUB_OVF_EN
    ,
    .ovf   (ovf1)
`endif
  );

`ifndef SERIAL_SUB_OVF_EN
  assign ovf8 = 1'b0;
  assign ovf1 = 1'b0;
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor for the 8-bit instance.
  always @(negedge clk) begin
    if (done8 === 1'b1) begin
      if (q8.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL dut8 unexpected done: got done=1 expected none (cycle %0d)", cyc);
      end else begin
        e8 = q8.pop_front();
        check("dut8 diff", {24'h0, diff8}, e8.diff);
        check("dut8 bout", {31'h0, bout8}, {31'h0, e8.bout});
`ifdef SERIAL_SUB_OVF_EN
        check("dut8 ovf", {31'h0, ovf8}, {31'h0, e8.ovf});
`endif
        check("dut8 done cycle", cyc, e8.cyc);
        check("dut8 busy at done", {31'h0, busy8}, 32'h0);
        hold8 = e8.diff[7:0];
      end
    end
  end

  // Monitor for the 1-bit instance.
  always @(negedge clk) begin
    if (done1 === 1'b1) begin
      if (q1.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL dut1 unexpected done: got done=1 expected none (cycle %0d)", cyc);
      end else begin
        e1 = q1.pop_front();
        check("dut1 diff", {31'h0, diff1}, e1.diff);
        check("dut1 bout", {31'h0, bout1}, {31'h0, e1.bout});
`ifdef SERIAL_SUB_OVF_EN
        check("dut1 ovf", {31'h0, ovf1}, {31'h0, e1.ovf});
`endif
        check("dut1 done cycle", cyc, e1.cyc);
      end
    end
  end

  task automatic push8(input logic [7:0] ed, input logic eb, input logic eo, input int dc);
    exp_t e;
    e.diff = {24'h0, ed};
    e.bout = eb;
    e.ovf  = eo;
    e.cyc  = dc;
    q8.push_back(e);
  endtask

  // Called just after a rising edge; leaves the bench just after the accepting edge.
  task automatic issue8(input logic [7:0] ia, input logic [7:0] ib, input logic ibin,
                        input bit push, input logic [7:0] ed, input logic eb, input logic eo);
    int n = 0;
    while (busy8 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (busy8) begin
      checks++;
      errors++;
      $display("FAIL dut8 idle wait: got busy=1 expected 0 within 100 cycles");
    end
    a8 = ia;
    b8 = ib;
    bin8 = ibin;
    start8 = 1'b1;
    @(posedge clk);
    #1;
    start8 = 1'b0;
    if (push) push8(ed, eb, eo, cyc + 8);
  endtask

  task automatic issue1(input logic ia, input logic ib, input logic ibin,
                        input logic ed, input logic eb, input logic eo);
    exp_t e;
    int n = 0;
    while (busy1 && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    a1 = ia;
    b1 = ib;
    bin1 = ibin;
    start1 = 1'b1;
    @(posedge clk);
    #1;
    start1 = 1'b0;
    e.diff = {31'h0, ed};
    e.bout = eb;
    e.ovf  = eo;
    e.cyc  = cyc + 1;
    q1.push_back(e);
  endtask

  task automatic drain(input int limit);
    int n = 0;
    while ((q8.size() != 0 || q1.size() != 0) && n < limit) begin
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    if (q8.size() != 0 || q1.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d/%0d results pending expected 0/0", q8.size(), q1.size());
    end
  endtask

  // WIDTH=1 truth tables indexed by {a, b, bin}.
  logic [7:0] tab_d   = 8'b1001_0110;
  logic [7:0] tab_bo  = 8'b1000_1110;
  logic [7:0] tab_ovf = 8'b0010_0100;

  initial begin
    int nbusy;
    int n;
    rst = 1'b1;
    start8 = 1'b0; a8 = 8'h00; b8 = 8'h00; bin8 = 1'b0;
    start1 = 1'b0; a1 = 1'b0;  b1 = 1'b0;  bin1 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset busy8", {31'h0, busy8}, 32'h0);
    check("reset done8", {31'h0, done8}, 32'h0);
    check("reset diff8", {24'h0, diff8}, 32'h0);
    check("reset bout8", {31'h0, bout8}, 32'h0);
    check("reset ovf8", {31'h0, ovf8}, 32'h0);
    check("reset busy1", {31'h0, busy1}, 32'h0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // 5 - 3, plus busy duration.
    issue8(8'd5, 8'd3, 1'b0, 1'b1, 8'd2, 1'b0, 1'b0);
    nbusy = 0;
    for (int i = 0; i < 10; i++) begin
      if (busy8) nbusy++;
      if (i == 4) check("hold diff mid-run", {24'h0, diff8}, 32'h0);
      @(posedge clk);
      #1;
    end
    check("busy cycles", nbusy, 8);
    drain(50);

    issue8(8'h00, 8'h01, 1'b0, 1'b1, 8'hFF, 1'b1, 1'b0);
    issue8(8'h00, 8'h00, 1'b1, 1'b1, 8'hFF, 1'b1, 1'b0);
    issue8(8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b0, 1'b1);
    issue8(8'h7F, 8'hFF, 1'b0, 1'b1, 8'h80, 1'b1, 1'b1);
    drain(50);

    // Start mid-run ignored, then start during DONE accepted.
    issue8(8'h64, 8'h1E, 1'b0, 1'b1, 8'h46, 1'b0, 1'b0);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    check("hold diff during run", {24'h0, diff8}, {24'h0, hold8});
    a8 = 8'hFF; b8 = 8'h00; bin8 = 1'b1; start8 = 1'b1;
    @(posedge clk);
    #1;
    start8 = 1'b0;
    check("busy after ignored start", {31'h0, busy8}, 32'h1);
    n = 0;
    while (!done8 && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("done seen before back-to-back", {31'h0, done8}, 32'h1);
    a8 = 8'h01; b8 = 8'h02; bin8 = 1'b0; start8 = 1'b1;
    @(posedge clk);
    #1;
    start8 = 1'b0;
    push8(8'hFF, 1'b1, 1'b0, cyc + 8);
    check("busy after done-cycle start", {31'h0, busy8}, 32'h1);
    drain(50);

    // Reset during RUN aborts and clears the published result.
    issue8(8'h55, 8'h22, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("abort busy8", {31'h0, busy8}, 32'h0);
    check("abort done8", {31'h0, done8}, 32'h0);
    check("abort diff8", {24'h0, diff8}, 32'h0);
    check("abort bout8", {31'h0, bout8}, 32'h0);
    hold8 = 8'h00;
    repeat (12) begin
      @(posedge clk);
      #1;
    end
    issue8(8'h55, 8'h22, 1'b0, 1'b1, 8'h33, 1'b0, 1'b0);
    drain(50);

    // WIDTH=1: every (a, b, bin) combination.
    for (int i = 0; i < 8; i++) begin
      logic [2:0] idx;
      idx = 3'(i);
      issue1(idx[2], idx[1], idx[0], tab_d[i], tab_bo[i], tab_ovf[i]);
    end
    drain(50);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
